// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter merging instruction and data valid/ready ports onto one
// registered memory port, with a per-transaction watchdog and a one-cycle response phase.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  imem_valid_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]            imem_we_i,
    output logic                  imem_ready_o,
    output logic [WORD_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_err_o,

    input  logic                  dmem_valid_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]            dmem_we_i,
    output logic                  dmem_ready_o,
    output logic [WORD_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_err_o,

    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_we_o,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);
    localparam logic          GRANT_I   = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StRespI,
        StRespD
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [CW-1:0]           wdog_q, wdog_d;

    logic                    mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_we_q, mem_we_d;

    logic                    imem_ready_q, imem_ready_d;
    logic                    imem_err_q, imem_err_d;
    logic [WORD_WIDTH-1:0]   imem_rdata_q, imem_rdata_d;
    logic                    dmem_ready_q, dmem_ready_d;
    logic                    dmem_err_q, dmem_err_d;
    logic [WORD_WIDTH-1:0]   dmem_rdata_q, dmem_rdata_d;

    logic                    pick_dmem;
    logic                    txn_abort;
    logic                    txn_done;
    logic [WORD_WIDTH-1:0]   txn_rdata;

    // On a tie the side that did not win last time is served.
    assign pick_dmem = dmem_valid_i && (!imem_valid_i || (last_grant_q == GRANT_I));

    // A handshake on the final watchdog cycle still counts as success.
    assign txn_abort = !mem_ready_i && (wdog_q == WDOG_LAST);
    assign txn_done  = mem_ready_i || txn_abort;
    assign txn_rdata = mem_ready_i ? mem_rdata_i : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        imem_ready_d = 1'b0;
        imem_err_d   = 1'b0;
        imem_rdata_d = imem_rdata_q;
        dmem_ready_d = 1'b0;
        dmem_err_d   = 1'b0;
        dmem_rdata_d = dmem_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_dmem) begin
                    state_d      = StBusyD;
                    last_grant_d = ~GRANT_I;
                    wdog_d       = '0;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = dmem_addr_i;
                    mem_wdata_d  = dmem_wdata_i;
                    mem_we_d     = dmem_we_i;
                end else if (imem_valid_i) begin
                    state_d      = StBusyI;
                    last_grant_d = GRANT_I;
                    wdog_d       = '0;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = imem_addr_i;
                    mem_wdata_d  = imem_wdata_i;
                    mem_we_d     = imem_we_i;
                end
            end
            StBusyI, StBusyD: begin
                if (txn_done) begin
                    mem_valid_d = 1'b0;
                    if (state_q == StBusyD) begin
                        state_d      = StRespD;
                        dmem_ready_d = 1'b1;
                        dmem_err_d   = txn_abort;
                        dmem_rdata_d = txn_rdata;
                    end else begin
                        state_d      = StRespI;
                        imem_ready_d = 1'b1;
                        imem_err_d   = txn_abort;
                        imem_rdata_d = txn_rdata;
                    end
                end else begin
                    wdog_d = wdog_q + CW'(1);
                end
            end
            StRespI, StRespD: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= GRANT_I;
            wdog_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= '0;
            imem_ready_q <= 1'b0;
            imem_err_q   <= 1'b0;
            imem_rdata_q <= '0;
            dmem_ready_q <= 1'b0;
            dmem_err_q   <= 1'b0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            imem_ready_q <= imem_ready_d;
            imem_err_q   <= imem_err_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_err_q   <= dmem_err_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    assign mem_valid_o  = mem_valid_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;
    assign imem_ready_o = imem_ready_q;
    assign imem_err_o   = imem_err_q;
    assign imem_rdata_o = imem_rdata_q;
    assign dmem_ready_o = dmem_ready_q;
    assign dmem_err_o   = dmem_err_q;
    assign dmem_rdata_o = dmem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-scheduling model. A second instance with a short watchdog covers timeouts.
module tb_mem_bus_arbiter;

    localparam int unsigned T  = 8;
    localparam int unsigned T4 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid, dmem_valid, mem_ready;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, mem_rdata;
    logic [3:0]  imem_we, dmem_we;

    logic        imem_ready, imem_err, dmem_ready, dmem_err, mem_valid;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    logic        t4_imem_ready, t4_imem_err, t4_dmem_ready, t4_dmem_err, t4_mem_valid;
    logic [31:0] t4_imem_rdata, t4_dmem_rdata, t4_mem_addr, t4_mem_wdata;
    logic [3:0]  t4_mem_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .imem_valid_i(imem_valid), .imem_addr_i(imem_addr), .imem_wdata_i(imem_wdata),
        .imem_we_i(imem_we), .imem_ready_o(imem_ready), .imem_rdata_o(imem_rdata),
        .imem_err_o(imem_err),
        .dmem_valid_i(dmem_valid), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
        .dmem_we_i(dmem_we), .dmem_ready_o(dmem_ready), .dmem_rdata_o(dmem_rdata),
        .dmem_err_o(dmem_err),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT(T4)) dut_t4 (
        .clk(clk), .rst(rst),
        .imem_valid_i(imem_valid), .imem_addr_i(imem_addr), .imem_wdata_i(imem_wdata),
        .imem_we_i(imem_we), .imem_ready_o(t4_imem_ready), .imem_rdata_o(t4_imem_rdata),
        .imem_err_o(t4_imem_err),
        .dmem_valid_i(dmem_valid), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
        .dmem_we_i(dmem_we), .dmem_ready_o(t4_dmem_ready), .dmem_rdata_o(t4_dmem_rdata),
        .dmem_err_o(t4_dmem_err),
        .mem_valid_o(t4_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(t4_mem_addr),
        .mem_wdata_o(t4_mem_wdata), .mem_we_o(t4_mem_we), .mem_rdata_i(mem_rdata)
    );

    // Leaves the bench at the negedge of the first post-reset cycle (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_valid = 1'b0; dmem_valid = 1'b0; mem_ready = 1'b0;
        imem_addr = '0; imem_wdata = '0; imem_we = '0;
        dmem_addr = '0; dmem_wdata = '0; dmem_we = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        dmem_valid = 1'b1; dmem_addr = 32'hABC0; dmem_wdata = 32'h5A5A; dmem_we = 4'h5;
        @(negedge clk);
        checks++; if (mem_addr !== 32'hABC0) begin errors++;
            $display("FAIL reset_pre mem_addr: got %h want %h", mem_addr, 32'hABC0); end
        mem_ready = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_ready = 1'b0; dmem_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem_valid !== 1'b0) begin errors++;
            $display("FAIL reset mem_valid: got %b want 0", mem_valid); end
        checks++; if (mem_addr !== 32'h0) begin errors++;
            $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_we !== 4'h0) begin errors++;
            $display("FAIL reset mem_we: got %h want 0", mem_we); end
        checks++; if ({imem_ready, dmem_ready, imem_err, dmem_err} !== 4'h0) begin errors++;
            $display("FAIL reset ready/err: got %b want 0000",
                     {imem_ready, dmem_ready, imem_err, dmem_err}); end
        checks++; if (dmem_rdata !== 32'h0 || imem_rdata !== 32'h0) begin errors++;
            $display("FAIL reset rdata: got %h/%h want 0/0", imem_rdata, dmem_rdata); end
    endtask

    task automatic test_single_read();
        do_reset();
        imem_valid = 1'b1; imem_addr = 32'h100; imem_we = 4'h0; imem_wdata = 32'h1;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin errors++;
            $display("FAIL single c1: got valid=%b addr=%h want 1/100", mem_valid, mem_addr); end
        checks++; if (imem_ready !== 1'b0) begin errors++;
            $display("FAIL single early ready: got %b want 0", imem_ready); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ready = 1'b0; imem_valid = 1'b0;
        checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL single c2: got ready=%b rdata=%h want 1/deadbeef",
                     imem_ready, imem_rdata); end
        checks++; if (dmem_ready !== 1'b0 || imem_err !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL single c2 side: got dready=%b err=%b valid=%b want 0/0/0",
                     dmem_ready, imem_err, mem_valid); end
        @(negedge clk);
        checks++; if (imem_ready !== 1'b0) begin errors++;
            $display("FAIL single pulse: got %b want 0", imem_ready); end
    endtask

    task automatic test_tie();
        do_reset();
        dmem_valid = 1'b1; dmem_addr = 32'h2000; dmem_we = 4'hF; dmem_wdata = 32'h11111111;
        imem_valid = 1'b1; imem_addr = 32'h4; imem_we = 4'h0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h2000 || mem_we !== 4'hF || mem_wdata !== 32'h11111111)
        begin errors++;
            $display("FAIL tie first: got addr=%h we=%h wdata=%h want 2000/f/11111111",
                     mem_addr, mem_we, mem_wdata); end
        mem_ready = 1'b1; mem_rdata = 32'hAAAA0001;
        @(negedge clk);
        mem_ready = 1'b0; dmem_valid = 1'b0;
        checks++; if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin errors++;
            $display("FAIL tie dready: got d=%b i=%b want 1/0", dmem_ready, imem_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 4'h0) begin
            errors++;
            $display("FAIL tie second: got valid=%b addr=%h we=%h want 1/4/0",
                     mem_valid, mem_addr, mem_we); end
        mem_ready = 1'b1; mem_rdata = 32'hBBBB0002;
        @(negedge clk);
        mem_ready = 1'b0; imem_valid = 1'b0;
        checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'hBBBB0002 || dmem_ready !== 1'b0)
        begin errors++;
            $display("FAIL tie iready: got i=%b rdata=%h d=%b want 1/bbbb0002/0",
                     imem_ready, imem_rdata, dmem_ready); end
    endtask

    task automatic test_round_robin();
        do_reset();
        imem_valid = 1'b1; imem_addr = 32'h1000; imem_we = 4'h0;
        dmem_valid = 1'b1; dmem_addr = 32'hD000; dmem_we = 4'h3;
        for (int k = 0; k < 6; k++) begin
            logic want_d;
            want_d = (k % 2 == 0);
            @(negedge clk);
            checks++; if (mem_addr !== (want_d ? 32'hD000 : 32'h1000)) begin errors++;
                $display("FAIL rr grant %0d: got addr=%h want %h", k, mem_addr,
                         want_d ? 32'hD000 : 32'h1000); end
            mem_ready = 1'b1; mem_rdata = 32'(k);
            @(negedge clk);
            mem_ready = 1'b0;
            checks++; if (dmem_ready !== want_d || imem_ready !== !want_d) begin errors++;
                $display("FAIL rr ready %0d: got d=%b i=%b want %b/%b", k, dmem_ready,
                         imem_ready, want_d, !want_d); end
            @(negedge clk);
        end
        imem_valid = 1'b0; dmem_valid = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        mem_ready = 1'b1;  // ignored while nothing is outstanding
        imem_valid = 1'b1; imem_addr = 32'h300; imem_wdata = 32'h55; imem_we = 4'h3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            mem_ready = (c == 5);
            mem_rdata = (c == 5) ? 32'h600DF00D : $urandom;
            if (c == 3) imem_addr = 32'hFFFF;
            checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'h55
                          || mem_we !== 4'h3 || imem_ready !== 1'b0) begin errors++;
                $display("FAIL wait c%0d: got v=%b a=%h w=%h we=%h r=%b want 1/300/55/3/0",
                         c, mem_valid, mem_addr, mem_wdata, mem_we, imem_ready); end
        end
        @(negedge clk);
        mem_ready = 1'b0; imem_valid = 1'b0;
        checks++; if (imem_ready !== 1'b1 || imem_err !== 1'b0 || imem_rdata !== 32'h600DF00D)
        begin errors++;
            $display("FAIL wait c6: got r=%b e=%b d=%h want 1/0/600df00d",
                     imem_ready, imem_err, imem_rdata); end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_valid = 1'b1; dmem_addr = 32'h40; dmem_we = 4'h0; dmem_wdata = 32'h0BAD0BAD;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++; if (t4_dmem_ready !== 1'b1 || t4_dmem_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL to first: got r=%b d=%h want 1/cafef00d", t4_dmem_ready,
                     t4_dmem_rdata); end
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            checks++; if (t4_mem_valid !== 1'b1 || t4_dmem_ready !== 1'b0
                          || t4_mem_addr !== 32'h40 || t4_mem_wdata !== 32'h0BAD0BAD
                          || t4_mem_we !== 4'h0) begin errors++;
                $display("FAIL to busy c%0d: got v=%b r=%b a=%h w=%h we=%h", k, t4_mem_valid,
                         t4_dmem_ready, t4_mem_addr, t4_mem_wdata, t4_mem_we); end
        end
        @(negedge clk);
        dmem_valid = 1'b0;
        checks++; if (t4_mem_valid !== 1'b0 || t4_dmem_err !== 1'b1 || t4_dmem_ready !== 1'b1
                      || t4_dmem_rdata !== 32'h0) begin errors++;
            $display("FAIL to abort: got v=%b e=%b r=%b d=%h want 0/1/1/0", t4_mem_valid,
                     t4_dmem_err, t4_dmem_ready, t4_dmem_rdata); end
        checks++; if (t4_imem_ready !== 1'b0 || t4_imem_err !== 1'b0 || t4_imem_rdata !== 32'h0)
        begin errors++;
            $display("FAIL to other side: got r=%b e=%b d=%h want 0/0/0", t4_imem_ready,
                     t4_imem_err, t4_imem_rdata); end
        @(negedge clk);
        dmem_valid = 1'b1; dmem_addr = 32'h44;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mem_ready = (k == 4);
            mem_rdata = 32'h12345678;
        end
        @(negedge clk);
        mem_ready = 1'b0; dmem_valid = 1'b0;
        checks++; if (t4_dmem_ready !== 1'b1 || t4_dmem_err !== 1'b0
                      || t4_dmem_rdata !== 32'h12345678) begin errors++;
            $display("FAIL to edge: got r=%b e=%b d=%h want 1/0/12345678", t4_dmem_ready,
                     t4_dmem_err, t4_dmem_rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dmem_valid = 1'b1; dmem_addr = 32'h60;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h60) begin errors++;
            $display("FAIL rmid start: got v=%b a=%h want 1/60", mem_valid, mem_addr); end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        checks++; if (mem_valid !== 1'b0 || dmem_ready !== 1'b0 || dmem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmid abort: got v=%b r=%b d=%h want 0/0/0", mem_valid, dmem_ready,
                     dmem_rdata); end
        imem_valid = 1'b1; imem_addr = 32'h70; dmem_valid = 1'b1; dmem_addr = 32'h88;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h88 || dmem_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid regrant: got v=%b a=%h r=%b want 1/88/0", mem_valid, mem_addr,
                     dmem_ready); end
        mem_ready = 1'b1; mem_rdata = 32'h4242;
        @(negedge clk);
        mem_ready = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0;
        checks++; if (dmem_ready !== 1'b1 || dmem_rdata !== 32'h4242 || imem_ready !== 1'b0)
        begin errors++;
            $display("FAIL rmid resp: got d=%b data=%h i=%b want 1/4242/0", dmem_ready,
                     dmem_rdata, imem_ready); end
    endtask

    // Model: each transaction is scheduled arithmetically from its grant cycle g and memory
    // latency lat; beats g+1..fin are on the bus and the response lands at fin+1.
    task automatic test_random();
        int          idle_at, g, lat, fin;
        bit          last_d, cur, cur_d, pend_i, pend_d, err_x;
        logic [31:0] ia, iw, da, dw, rd;
        logic [3:0]  iwe, dwe;
        logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
        logic [3:0]  e_we;
        bit          e_mv, e_ir, e_dr, e_ie, e_de;
        do_reset();
        idle_at = 0; last_d = 1'b0; cur = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
        g = 0; lat = 0; fin = 0; rd = '0; cur_d = 1'b0;
        ia = '0; iw = '0; da = '0; dw = '0; iwe = '0; dwe = '0;
        e_addr = '0; e_wdata = '0; e_we = '0; e_irdata = '0; e_drdata = '0;
        for (int c = 0; c < 600; c++) begin
            e_mv  = cur && c >= g + 1 && c <= fin;
            err_x = lat > int'(T);
            e_ir  = cur && !cur_d && c == fin + 1;
            e_dr  = cur && cur_d && c == fin + 1;
            e_ie  = e_ir && err_x;
            e_de  = e_dr && err_x;
            if (e_ir) e_irdata = err_x ? 32'h0 : rd;
            if (e_dr) e_drdata = err_x ? 32'h0 : rd;
            checks++; if (mem_valid !== e_mv || mem_addr !== e_addr || mem_wdata !== e_wdata
                          || mem_we !== e_we) begin errors++;
                $display("FAIL rand bus c%0d: got v=%b a=%h w=%h we=%h want %b/%h/%h/%h", c,
                         mem_valid, mem_addr, mem_wdata, mem_we, e_mv, e_addr, e_wdata, e_we);
            end
            checks++; if (imem_ready !== e_ir || imem_err !== e_ie || imem_rdata !== e_irdata)
            begin errors++;
                $display("FAIL rand imem c%0d: got r=%b e=%b d=%h want %b/%b/%h", c,
                         imem_ready, imem_err, imem_rdata, e_ir, e_ie, e_irdata); end
            checks++; if (dmem_ready !== e_dr || dmem_err !== e_de || dmem_rdata !== e_drdata)
            begin errors++;
                $display("FAIL rand dmem c%0d: got r=%b e=%b d=%h want %b/%b/%h", c,
                         dmem_ready, dmem_err, dmem_rdata, e_dr, e_de, e_drdata); end
            if (cur && c == fin + 1) begin
                cur = 1'b0;
                if (cur_d) pend_d = 1'b0; else pend_i = 1'b0;
                idle_at = c + 1;
            end
            if (!pend_i && $urandom_range(0, 2) == 0) begin
                pend_i = 1'b1; ia = $urandom; iw = $urandom; iwe = 4'($urandom);
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1'b1; da = $urandom; dw = $urandom; dwe = 4'($urandom);
            end
            if (!cur && c == idle_at) begin
                if (pend_i || pend_d) begin
                    cur    = 1'b1;
                    cur_d  = pend_d && (!pend_i || !last_d);
                    last_d = cur_d;
                    g      = c;
                    lat    = $urandom_range(1, T + 1);
                    fin    = g + ((lat > int'(T)) ? int'(T) : lat);
                    e_addr = cur_d ? da : ia;
                    e_wdata = cur_d ? dw : iw;
                    e_we   = cur_d ? dwe : iwe;
                end else begin
                    idle_at = c + 1;
                end
            end
            imem_valid = pend_i; imem_addr = ia; imem_wdata = iw; imem_we = iwe;
            dmem_valid = pend_d; dmem_addr = da; dmem_wdata = dw; dmem_we = dwe;
            mem_rdata = $urandom;
            if (cur && c >= g + 1 && c <= fin) mem_ready = (c == g + lat);
            else mem_ready = 1'($urandom_range(0, 1));
            if (cur && c == g + lat && lat <= int'(T)) rd = mem_rdata;
            @(negedge clk);
        end
        imem_valid = 1'b0; dmem_valid = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_tie();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1, "time limit");
    end

endmodule
